mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 114 +++++++++++
 tb/tb_mem_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter for instruction fetch and multi-byte MEM accesses
// MEM wins over IF; loads and stores of 1/2/4 bytes run one byte per cycle.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [7:0]        if_byte_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {IDLE, IF_PASS, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        last_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      last_q  <= 2'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      k       <= 2'd0;
    end else begin
      case (state)
        IDLE, IF_PASS: begin
          if (mem_req_i) begin
            we_q    <= mem_we_i;
            base_q  <= mem_addr_i;
            last_q  <= (mem_len_i == 2'b00) ? 2'd0 : (mem_len_i == 2'b01) ? 2'd1 : 2'd3;
            wdata_q <= mem_wdata_i;
            k       <= 2'd0;
            if (!mem_we_i) rdata_q <= 32'h0;
            state   <= mem_we_i ? MEM_WR : MEM_RD;
          end else begin
            state <= if_req_i ? IF_PASS : IDLE;
          end
        end
        MEM_RD: begin
          // RAM is one cycle behind: this cycle's ram_din_i belongs to byte k-1
          if (k != 2'd0) rdata_q[{k - 2'd1, 3'b000} +: 8] <= ram_din_i;
          if (k == last_q) state <= DONE;
          else             k     <= k + 2'd1;
        end
        MEM_WR: begin
          if (k == last_q) state <= DONE;
          else             k     <= k + 2'd1;
        end
        DONE: begin
          if (!we_q) rdata_q[{last_q, 3'b000} +: 8] <= ram_din_i;
          k     <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wr_o    = 1'b0;
    ram_dout_o  = 8'h0;
    if_stall_o  = 1'b0;
    mem_rdata_o = rdata_q;
    case (state)
      IDLE, IF_PASS: begin
        if (mem_req_i)     if_stall_o = 1'b1;
        else if (if_req_i) ram_addr_o = if_addr_i;
      end
      MEM_RD: begin
        if_stall_o = 1'b1;
        ram_addr_o = base_q + ADDR_W'(k);
      end
      MEM_WR: begin
        if_stall_o = 1'b1;
        ram_addr_o = base_q + ADDR_W'(k);
        ram_wr_o   = 1'b1;
        ram_dout_o = wdata_q[{k, 3'b000} +: 8];
      end
      DONE: begin
        if_stall_o = 1'b1;
        // the final load byte arrives during DONE; show it alongside the done pulse
        if (!we_q) mem_rdata_o[{last_q, 3'b000} +: 8] = ram_din_i;
      end
      default: ;
    endcase
  end

  assign if_byte_o  = ram_din_i;
  assign mem_done_o = (state == DONE);
  assign mem_busy_o = (state == MEM_RD) || (state == MEM_WR) || (state == DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a byte-array model
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [7:0]  if_byte;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_busy;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int checks = 0;
  int errors = 0;

  bit [7:0] ram     [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_byte_o(if_byte), .if_stall_o(if_stall),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_len_i(mem_len),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .mem_busy_o(mem_busy), .ram_addr_o(ram_addr), .ram_wr_o(ram_wr),
    .ram_dout_o(ram_dout), .ram_din_i(ram_din)
  );

  always #5 clk = ~clk;

  // synchronous byte RAM, read-before-write
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    ram_din <= rd;
    if (ram_wr) ram[ram_addr] = ram_dout;
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_mem(input bit we, input logic [31:0] base, input logic [1:0] len,
                        input logic [31:0] wdata, input bit with_if);
    int n;
    int cyc;
    int wr_cnt;
    bit seen;
    logic [31:0] exp_rd;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    exp_rd = 32'h0;
    for (int i = 0; i < n; i++) exp_rd |= 32'(ref_rd(base + 32'(i))) << (8 * i);

    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_addr = base; mem_len = len; mem_wdata = wdata;
    if (with_if) if_req = 1'b1;
    @(negedge clk);
    check("accept_stall", 32'(if_stall), 32'd1);
    check("accept_busy", 32'(mem_busy), 32'd0);
    @(posedge clk); #1;
    // scramble request fields: the latched copy must govern the access
    mem_we = ~we; mem_addr = ~base; mem_len = ~len; mem_wdata = ~wdata;

    cyc = 0; wr_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_done) seen = 1'b1;
      else begin
        check("active_stall_busy", {30'd0, if_stall, mem_busy}, 32'd3);
        if (cyc <= n) begin
          check("ram_addr", ram_addr, base + 32'(cyc - 1));
          check("ram_wr", 32'(ram_wr), 32'(we));
          if (we) check("ram_dout", 32'(ram_dout), 32'(wdata[8*(cyc-1) +: 8]));
        end
        if (ram_wr) wr_cnt++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(n + 1));
    check("done_stall_busy", {30'd0, if_stall, mem_busy}, 32'd3);
    check("done_no_wr", 32'(ram_wr), 32'd0);
    if (!we) check("rdata", mem_rdata, exp_rd);
    else begin
      check("wr_count", 32'(wr_cnt), 32'(n));
      for (int i = 0; i < n; i++) ref_mem[base + 32'(i)] = wdata[8*i +: 8];
    end

    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_len = 2'b00; mem_wdata = 32'h0;
    @(negedge clk);
    check("after_done", {30'd0, mem_done, mem_busy}, 32'd0);
    if (!we) check("rdata_hold", mem_rdata, exp_rd);
    else for (int i = 0; i < n; i++)
      check("ram_byte", 32'(ram_rd(base + 32'(i))), 32'(ref_rd(base + 32'(i))));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] if_exp [4];
    bit we;
    logic [1:0] len;
    logic [31:0] base;
    bit wif;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_len = 2'b00; mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {28'd0, if_stall, mem_done, mem_busy, ram_wr}, 32'd0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_dout", 32'(ram_dout), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // instruction fetch stream
    if_exp[0] = 8'h13; if_exp[1] = 8'h02; if_exp[2] = 8'h00; if_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(i), if_exp[i]);
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin if_req = 1'b1; if_addr = 32'h100 + 32'(i); end
      else if_req = 1'b0;
      @(negedge clk);
      if (i < 4) check("if_addr", ram_addr, 32'h100 + 32'(i));
      if (i > 0) check("if_byte", 32'(if_byte), 32'(if_exp[i-1]));
      check("if_stall", 32'(if_stall), 32'd0);
    end

    // 4-byte load
    preload(32'h200, 8'h78); preload(32'h201, 8'h56);
    preload(32'h202, 8'h34); preload(32'h203, 8'h12);
    do_mem(1'b0, 32'h200, 2'b10, 32'h0, 1'b0);
    check("load4_value", mem_rdata, 32'h12345678);

    // 1-byte store
    do_mem(1'b1, 32'h300, 2'b00, 32'hAABBCCDD, 1'b0);
    check("store1_byte", 32'(ram_rd(32'h300)), 32'hDD);
    check("store1_next", 32'(ram_rd(32'h301)), 32'h00);

    // simultaneous IF + MEM, IF resumes after DONE
    if_addr = 32'h102;
    do_mem(1'b0, 32'h100, 2'b01, 32'h0, 1'b1);
    check("resume_stall", 32'(if_stall), 32'd0);
    check("resume_addr", ram_addr, 32'h102);
    @(posedge clk); #1; if_req = 1'b0;

    // 2-byte load wrapping past the top of the address space
    preload(32'hFFFFFFFF, 8'hAB); preload(32'h0, 8'hCD);
    do_mem(1'b0, 32'hFFFFFFFF, 2'b01, 32'h0, 1'b0);
    check("wrap_value", mem_rdata, 32'h0000CDAB);

    // reset in the 2nd write cycle of a 4-byte store
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_len = 2'b11; mem_wdata = 32'h44332211;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check("rst_mid_wr", 32'(ram_wr), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {28'd0, if_stall, mem_done, mem_busy, ram_wr}, 32'd0);
    check("abort_addr", ram_addr, 32'h0);
    check("abort_dout", 32'(ram_dout), 32'h0);
    check("abort_rdata", mem_rdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_quiet", {30'd0, mem_done, ram_wr}, 32'd0);
    end
    check("abort_b0", 32'(ram_rd(32'h500)), 32'h11);
    check("abort_b1", 32'(ram_rd(32'h501)), 32'h22);
    check("abort_b2", 32'(ram_rd(32'h502)), 32'h00);
    check("abort_b3", 32'(ram_rd(32'h503)), 32'h00);

    // randomized loads and stores against the byte-array model
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom_range(0, 1));
      len  = 2'($urandom_range(0, 3));
      base = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD + 32'($urandom_range(0, 2))
                                         : 32'h400 + 32'($urandom_range(0, 15));
      wif  = 1'($urandom_range(0, 1));
      if_addr = $urandom;
      do_mem(we, base, len, $urandom, wif);
      if (wif) begin
        check("rand_resume_addr", ram_addr, if_addr);
        check("rand_resume_stall", 32'(if_stall), 32'd0);
      end
      @(posedge clk); #1; if_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
